// File: rtl/feature_writeback_pkg.sv
// Shared types and elaboration helpers for the new-feature writeback stage.
//   state_e      : writeback run FSM states
//   calc_beats   : BRAM beats needed per output-feature vector
//   calc_addr_w  : beat address width covering a full run
//   relu_keep    : per-element ReLU decision from the element sign bit
package feature_writeback_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned calc_beats(input int unsigned num_feature_out,
                                             input int unsigned num_lanes);
    return num_feature_out / num_lanes;
  endfunction

  function automatic int unsigned calc_addr_w(input int unsigned num_subgraphs,
                                              input int unsigned beats);
    return $clog2(num_subgraphs * beats);
  endfunction

  // An element is kept unless ReLU is on and the element is negative.
  function automatic logic relu_keep(input logic en, input logic sign);
    return !(en && sign);
  endfunction

endpackage

// File: rtl/feature_writeback_ctrl_fifo.sv
// First-word-fall-through vector FIFO between the aggregator and the writeback FSM.
//   clk, rst          : clock, asynchronous active-high reset (empties the FIFO)
//   wr_en, wr_data    : push side; pushes while full are dropped by the guard
//   full              : no free entry
//   rd_en, rd_data    : pop side; rd_data always shows the head entry
//   empty             : no entry held
module feature_writeback_ctrl_fifo #(
  parameter int unsigned DATA_WIDTH = 704,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           do_wr;
  logic           do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rd_data = mem[rd_ptr[PTR_W-1:0]];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
  end

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/feature_writeback_ctrl.sv
// New-feature writeback stage: buffers whole output-feature vectors and
// serialises them into the feature BRAM NUM_LANES elements per beat.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : run request pulse (honoured in IDLE only)
//   num_vectors         : vectors in the run, sampled at start
//   base_addr           : first beat address, sampled at start
//   relu_en             : clamp negative elements to zero, sampled at start
//   new_feat/_vld/_rdy  : vector push handshake
//   wr_stall            : BRAM port unavailable this cycle
//   feat_bram_ena/addra/din : registered BRAM write beat
//   busy, done          : run in progress / end-of-run pulse
module feature_writeback_ctrl
  import feature_writeback_pkg::*;
#(
  parameter  int unsigned NEW_FEATURE_WIDTH = 44,
  parameter  int unsigned NUM_FEATURE_OUT   = 16,
  parameter  int unsigned NUM_LANES         = 1,
  parameter  int unsigned FIFO_DEPTH        = 4,
  parameter  int unsigned NUM_SUBGRAPHS     = 2708,
  localparam int unsigned BEATS  = calc_beats(NUM_FEATURE_OUT, NUM_LANES),
  localparam int unsigned ADDR_W = calc_addr_w(NUM_SUBGRAPHS, BEATS),
  localparam int unsigned VCNT_W = $clog2(NUM_SUBGRAPHS + 1)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [VCNT_W-1:0]                           num_vectors,
  input  logic [ADDR_W-1:0]                           base_addr,
  input  logic                                        relu_en,
  input  logic [NUM_FEATURE_OUT*NEW_FEATURE_WIDTH-1:0] new_feat,
  input  logic                                        new_feat_vld,
  output logic                                        new_feat_rdy,
  input  logic                                        wr_stall,
  output logic                                        feat_bram_ena,
  output logic [ADDR_W-1:0]                           feat_bram_addra,
  output logic [NUM_LANES*NEW_FEATURE_WIDTH-1:0]       feat_bram_din,
  output logic                                        busy,
  output logic                                        done
);

  localparam int unsigned EW        = NEW_FEATURE_WIDTH;
  localparam int unsigned VEC_BITS  = NUM_FEATURE_OUT * EW;
  localparam int unsigned BEAT_BITS = NUM_LANES * EW;
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((NUM_LANES == 0) || ((NUM_FEATURE_OUT % NUM_LANES) != 0)) begin : g_bad_lanes
    $error("NUM_LANES must divide NUM_FEATURE_OUT");
  end

  state_e                state;
  logic [VCNT_W-1:0]     num_reg;
  logic [VCNT_W-1:0]     vec_cnt;
  logic                  relu_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [VEC_BITS-1:0]   vec_reg;
  logic                  rst_done;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [VEC_BITS-1:0]   fifo_rdata;

  logic                  pop_c;
  logic                  issue_c;
  logic                  last_beat_c;
  logic [BEAT_BITS-1:0]  beat_raw_c;
  logic [BEAT_BITS-1:0]  beat_c;

  // Ready is held low until the first clock after reset release.
  assign new_feat_rdy = rst_done && !fifo_full;

  feature_writeback_ctrl_fifo #(
    .DATA_WIDTH (VEC_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (new_feat_vld && new_feat_rdy),
    .wr_data (new_feat),
    .full    (fifo_full),
    .rd_en   (pop_c),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty)
  );

  // Issue decision: beat 0 comes straight from the FIFO head on the pop
  // cycle, later beats from the shifted vector register.
  always_comb begin
    pop_c       = (state == RUN) && (beat_cnt == '0) && !fifo_empty &&
                  !wr_stall && (vec_cnt < num_reg);
    issue_c     = (state == RUN) && !wr_stall && ((beat_cnt != '0) || pop_c);
    last_beat_c = (beat_cnt == BEAT_W'(BEATS - 1));
    beat_raw_c  = (beat_cnt == '0) ? fifo_rdata[BEAT_BITS-1:0] : vec_reg[BEAT_BITS-1:0];
    beat_c      = '0;
    for (int j = 0; j < int'(NUM_LANES); j++) begin
      beat_c[j*EW +: EW] = relu_keep(relu_reg, beat_raw_c[j*EW + EW - 1]) ?
                           beat_raw_c[j*EW +: EW] : '0;
    end
  end

  // Run FSM with registered BRAM port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      num_reg         <= '0;
      vec_cnt         <= '0;
      relu_reg        <= 1'b0;
      addr_reg        <= '0;
      beat_cnt        <= '0;
      vec_reg         <= '0;
      rst_done        <= 1'b0;
      feat_bram_ena   <= 1'b0;
      feat_bram_addra <= '0;
      feat_bram_din   <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      rst_done      <= 1'b1;
      done          <= 1'b0;
      feat_bram_ena <= issue_c;

      if (issue_c) begin
        feat_bram_addra <= addr_reg;
        feat_bram_din   <= beat_c;
        addr_reg        <= addr_reg + ADDR_W'(1);
        beat_cnt        <= last_beat_c ? '0 : beat_cnt + BEAT_W'(1);
      end

      // Remaining beats sit at the bottom of vec_reg after each shift.
      if (pop_c) begin
        vec_reg <= fifo_rdata >> BEAT_BITS;
        vec_cnt <= vec_cnt + VCNT_W'(1);
      end else if (issue_c) begin
        vec_reg <= vec_reg >> BEAT_BITS;
      end

      case (state)
        IDLE: begin
          if (start) begin
            num_reg  <= num_vectors;
            relu_reg <= relu_en;
            addr_reg <= base_addr;
            vec_cnt  <= '0;
            beat_cnt <= '0;
            busy     <= 1'b1;
            if (num_vectors == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          // All vectors popped and the last beat already issued.
          if ((beat_cnt == '0) && (vec_cnt == num_reg)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feature_writeback_ctrl.sv
// Self-checking bench for feature_writeback_ctrl: directed tables, hand-written
// corner sequences and randomized runs compared against a queue-based model.
module tb_feature_writeback_ctrl;

  localparam int unsigned W   = 44;
  localparam int unsigned NFO = 16;
  localparam int unsigned AW  = 16;
  localparam int unsigned AW4 = 14;
  localparam int unsigned VW  = 12;
  localparam int unsigned DW  = 4 * W;

  typedef logic [NFO*W-1:0] vec_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] din; } wr_t;
  typedef struct { logic relu; logic [W-1:0] elem_in; logic [W-1:0] elem_exp; } relu_rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [VW-1:0] num_vectors;
  logic [AW-1:0] base_addr;
  logic          relu_en;
  vec_t          new_feat;
  logic          new_feat_vld;
  logic          new_feat_rdy;
  logic          wr_stall;
  logic          feat_bram_ena;
  logic [AW-1:0] feat_bram_addra;
  logic [W-1:0]  feat_bram_din;
  logic          busy;
  logic          done;

  logic           start4;
  logic [VW-1:0]  num4;
  logic [AW4-1:0] base4;
  vec_t           new_feat4;
  logic           vld4;
  logic           rdy4;
  logic           ena4;
  logic [AW4-1:0] addra4;
  logic [DW-1:0]  din4;
  logic           busy4;
  logic           done4;

  feature_writeback_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .base_addr(base_addr), .relu_en(relu_en), .new_feat(new_feat),
    .new_feat_vld(new_feat_vld), .new_feat_rdy(new_feat_rdy), .wr_stall(wr_stall),
    .feat_bram_ena(feat_bram_ena), .feat_bram_addra(feat_bram_addra),
    .feat_bram_din(feat_bram_din), .busy(busy), .done(done)
  );

  feature_writeback_ctrl #(.NUM_LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .num_vectors(num4),
    .base_addr(base4), .relu_en(1'b0), .new_feat(new_feat4),
    .new_feat_vld(vld4), .new_feat_rdy(rdy4), .wr_stall(1'b0),
    .feat_bram_ena(ena4), .feat_bram_addra(addra4),
    .feat_bram_din(din4), .busy(busy4), .done(done4)
  );

  int   assertions = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   done_cnt   = 0;
  int   done_cyc   = 0;
  int   done4_cnt  = 0;
  logic run_over   = 1'b0;

  vec_t model[$];
  wr_t  wq[$];
  int   wcyc[$];
  wr_t  w4q[$];
  wr_t  exp_q[$];
  relu_rec_t rtab[32];

  // Observe writes, done pulses and accepted pushes away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (feat_bram_ena) begin
      wq.push_back('{addr: feat_bram_addra, din: DW'(feat_bram_din)});
      wcyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ena4) w4q.push_back('{addr: AW'(addra4), din: din4});
    if (done4) done4_cnt++;
    if (new_feat_vld && new_feat_rdy && !rst) model.push_back(new_feat);
  end

  task automatic check_eq(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] elem_out(input vec_t v, input int i, input logic r);
    logic [W-1:0] e;
    e = v[i*W +: W];
    return (r && e[W-1]) ? '0 : e;
  endfunction

  function automatic vec_t ramp_vec(input int b);
    vec_t v;
    for (int i = 0; i < int'(NFO); i++) v[i*W +: W] = W'(b + i);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < int'(NFO); i++) v[i*W +: W] = W'({$urandom(), $urandom()});
    return v;
  endfunction

  task automatic clear_writes();
    wq.delete();
    wcyc.delete();
  endtask

  task automatic push_vec(input vec_t v);
    int t = 0;
    @(posedge clk); #1;
    new_feat     = v;
    new_feat_vld = 1'b1;
    @(negedge clk);
    while (!new_feat_rdy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!new_feat_rdy) check_eq("push_accept", new_feat_rdy, 1'b1);
    @(posedge clk); #1;
    new_feat_vld = 1'b0;
  endtask

  task automatic do_start(input int unsigned b, input int n, input logic r);
    @(posedge clk); #1;
    start       = 1'b1;
    base_addr   = AW'(b);
    num_vectors = VW'(n);
    relu_en     = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int t  = 0;
    while (done_cnt == d0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_eq("done_seen", done_cnt != d0, 1'b1);
  endtask

  // Reference: the next n accepted vectors, element k of vector v lands at base+v*16+k.
  task automatic build_exp(input int n, input int unsigned b, input logic r);
    exp_q.delete();
    for (int v = 0; v < n; v++) begin
      vec_t vec;
      if (model.size() == 0) begin
        check_eq("model_has_vector", 1'b0, 1'b1);
        break;
      end
      vec = model.pop_front();
      for (int k = 0; k < int'(NFO); k++) begin
        wr_t e;
        e.addr = AW'(b + v * NFO + k);
        e.din  = DW'(elem_out(vec, k, r));
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_run(input string name);
    check_eq($sformatf("%s_count", name), wq.size(), exp_q.size());
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_addr[%0d]", name, i), wq[i].addr, exp_q[i].addr);
      check_eq($sformatf("%s_din[%0d]", name, i), wq[i].din, exp_q[i].din);
    end
  endtask

  task automatic check_gaps(input string name, input int skip);
    int g = 0;
    for (int i = 1; i < wcyc.size(); i++)
      if (i != skip && wcyc[i] != wcyc[i-1] + 1) g++;
    check_eq(name, g, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int t;
    rst = 1'b1; start = 1'b0; num_vectors = '0; base_addr = '0; relu_en = 1'b0;
    new_feat = '0; new_feat_vld = 1'b0; wr_stall = 1'b0;
    start4 = 1'b0; num4 = '0; base4 = '0; new_feat4 = '0; vld4 = 1'b0;

    for (int i = 0; i < 16; i++) begin
      rtab[i]      = '{relu: 1'b1, elem_in: W'(i - 8), elem_exp: (i < 8) ? '0 : W'(i - 8)};
      rtab[16 + i] = '{relu: 1'b0, elem_in: W'(i - 8), elem_exp: W'(i - 8)};
    end

    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_ena", feat_bram_ena, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_rdy", new_feat_rdy, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("rdy_after_rst", new_feat_rdy, 1'b1);

    // Two ramp vectors, back to back.
    clear_writes();
    push_vec(ramp_vec(0));
    push_vec(ramp_vec(100));
    d0 = done_cnt;
    do_start(0, 2, 1'b0);
    check_eq("busy_run", busy, 1'b1);
    wait_done(500);
    build_exp(2, 0, 1'b0);
    check_run("basic");
    check_gaps("basic_gaps", -1);
    if (wcyc.size() > 0) check_eq("done_after_last", done_cyc, wcyc[wcyc.size()-1] + 1);
    repeat (3) @(negedge clk);
    check_eq("done_pulses", done_cnt - d0, 1);
    check_eq("idle_busy", busy, 1'b0);

    // Four-lane instance: beats packed low lane first.
    @(posedge clk); #1;
    check_eq("rdy4", rdy4, 1'b1);
    new_feat4 = ramp_vec(0); vld4 = 1'b1;
    @(posedge clk); #1;
    vld4 = 1'b0; start4 = 1'b1; base4 = AW4'(8); num4 = VW'(1);
    @(posedge clk); #1;
    start4 = 1'b0;
    t = 0;
    while (done4_cnt == 0 && t < 100) begin @(negedge clk); t++; end
    check_eq("lanes4_done", done4_cnt, 1);
    check_eq("lanes4_count", w4q.size(), 4);
    if (w4q.size() > 0) check_eq("lanes4_beat0", w4q[0].din, {44'd3, 44'd2, 44'd1, 44'd0});
    for (int k = 0; k < 4 && k < w4q.size(); k++) begin
      logic [DW-1:0] e;
      for (int j = 0; j < 4; j++) e[j*W +: W] = W'(4 * k + j);
      check_eq($sformatf("lanes4_addr[%0d]", k), w4q[k].addr, AW'(8 + k));
      check_eq($sformatf("lanes4_din[%0d]", k), w4q[k].din, e);
    end
    check_eq("lanes4_busy", busy4, 1'b0);

    // ReLU table, on then off.
    for (int r = 0; r < 2; r++) begin
      vec_t v;
      for (int i = 0; i < 16; i++) v[i*W +: W] = rtab[r*16 + i].elem_in;
      clear_writes();
      push_vec(v);
      do_start(32'h100, 1, rtab[r*16].relu);
      wait_done(300);
      void'(model.pop_front());
      check_eq($sformatf("relu%0d_count", r), wq.size(), 16);
      for (int i = 0; i < 16 && i < wq.size(); i++) begin
        check_eq($sformatf("relu%0d_addr[%0d]", r, i), wq[i].addr, AW'(32'h100 + i));
        check_eq($sformatf("relu%0d_din[%0d]", r, i), wq[i].din, DW'(rtab[r*16 + i].elem_exp));
      end
    end

    // Three-cycle stall landing on beat 5.
    clear_writes();
    push_vec(rand_vec());
    do_start(0, 1, 1'b0);
    repeat (5) @(posedge clk); #1;
    wr_stall = 1'b1;
    repeat (3) @(posedge clk); #1;
    wr_stall = 1'b0;
    wait_done(300);
    build_exp(1, 0, 1'b0);
    check_run("stall");
    if (wcyc.size() > 5) check_eq("stall_gap", wcyc[5] - wcyc[4], 4);
    check_gaps("stall_other_gaps", 5);

    // Fill the FIFO in IDLE, hold the fifth vector, then drain all five.
    clear_writes();
    for (int v = 0; v < 4; v++) push_vec(ramp_vec(16 * v));
    check_eq("full_rdy", new_feat_rdy, 1'b0);
    fork
      push_vec(ramp_vec(64));
      begin
        repeat (3) @(negedge clk);
        check_eq("held_rdy", new_feat_rdy, 1'b0);
        check_eq("held_count", model.size(), 4);
        do_start(0, 5, 1'b0);
        wait_done(500);
      end
    join
    build_exp(5, 0, 1'b0);
    check_run("full");
    check_gaps("full_gaps", -1);

    // Reset in the middle of vector 0, then an empty run.
    clear_writes();
    push_vec(rand_vec());
    push_vec(rand_vec());
    do_start(0, 2, 1'b0);
    t = 0;
    while (wq.size() < 7 && t < 200) begin @(negedge clk); t++; end
    #2; rst = 1'b1; #1;
    check_eq("abort_ena", feat_bram_ena, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_rdy", new_feat_rdy, 1'b0);
    model.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("abort_rdy_back", new_feat_rdy, 1'b1);
    clear_writes();
    d0 = done_cnt;
    do_start(0, 0, 1'b0);
    wait_done(50);
    repeat (3) @(negedge clk);
    check_eq("empty_run_writes", wq.size(), 0);
    check_eq("empty_run_pulses", done_cnt - d0, 1);
    check_eq("empty_run_busy", busy, 1'b0);

    // Randomized runs with surplus vectors, random stalls and address wrap.
    for (int it = 0; it < 8; it++) begin
      int n, pending, need, surplus, extra;
      int unsigned b;
      logic r;
      n       = $urandom_range(1, 4);
      r       = 1'($urandom_range(0, 1));
      b       = ($urandom_range(0, 2) == 0) ? 32'hFFF8 : 32'($urandom_range(0, 65535));
      pending = model.size();
      need    = (n > pending) ? n - pending : 0;
      surplus = (pending > n) ? pending - n : 0;
      extra   = $urandom_range(0, 4 - surplus);
      clear_writes();
      run_over = 1'b0;
      fork
        begin
          for (int p = 0; p < need + extra; p++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            push_vec(rand_vec());
          end
        end
        begin
          while (!run_over) begin
            @(posedge clk); #1;
            wr_stall = ($urandom_range(0, 3) == 0);
          end
          wr_stall = 1'b0;
        end
        begin
          do_start(b, n, r);
          wait_done(3000);
          run_over = 1'b1;
        end
      join
      build_exp(n, b, r);
      check_run($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/feature_writeback_ctrl.md
Name: feature_writeback_ctrl

Overview:
Next-generation new-feature writeback stage at the aggregator output. It accepts whole output-feature vectors (NUM_FEATURE_OUT elements) over a valid/ready handshake and buffers them in a FIFO. It then serialises each vector into the new-feature BRAM at NUM_LANES elements per write beat. It adds an optional ReLU per run, a run-time base address and vector count, write-port stall and busy/done status.

Parameters:
NEW_FEATURE_WIDTH, 44, signed width of one output-feature element
NUM_FEATURE_OUT, 16, elements per vector
NUM_LANES, 1, elements per BRAM beat; must divide NUM_FEATURE_OUT (elaboration error otherwise)
FIFO_DEPTH, 4, vectors buffered; power of two, >=2
NUM_SUBGRAPHS, 2708, maximum vectors per run
BEATS (local), NUM_FEATURE_OUT/NUM_LANES
ADDR_W (local), $clog2(NUM_SUBGRAPHS*BEATS)
VCNT_W (local), $clog2(NUM_SUBGRAPHS+1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  one-cycle pulse; begins a run; ignored unless idle
num_vectors  in  VCNT_W  vectors in run; sampled at start
base_addr  in  ADDR_W  first BRAM beat address; sampled at start
relu_en  in  1  clamp negatives to 0; sampled at start
new_feat  in  NUM_FEATURE_OUT*NEW_FEATURE_WIDTH  packed vector; element i at bits [i*W +: W]
new_feat_vld  in  1  vector valid
new_feat_rdy  out  1  FIFO can accept a vector
wr_stall  in  1  BRAM port borrowed; no beat may be issued
feat_bram_ena  out  1  write strobe
feat_bram_addra  out  ADDR_W  beat address
feat_bram_din  out  NUM_LANES*NEW_FEATURE_WIDTH  beat data; lane j at bits [j*W +: W]
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset: all outputs 0 except new_feat_rdy=0, which goes to 1 on the first cycle after rst deasserts. FIFO emptied, state IDLE, all counters 0. Reset mid-run aborts immediately. No further writes occur and the FIFO contents are lost.
- Push: a transfer happens when new_feat_vld && new_feat_rdy. new_feat_rdy = !fifo_full, registered-free (combinational from FIFO flag). Pushes are accepted in every state, including IDLE, so vectors may arrive before start. vld while full is held off with no loss.
- FSM IDLE -> RUN on start; base/num/relu are latched and vec_cnt=0, beat_cnt=0. If num_vectors==0, go IDLE -> DONE -> IDLE and issue no writes.
- RUN: an element is the vector's lane data. Pop happens when beat_cnt==0 && !fifo_empty && !wr_stall && vec_cnt<num. The popped vector loads vec_reg, and beat 0 is registered onto outputs the next cycle.
- Beat k, lane j carries element k*NUM_LANES+j. Address = base + vec_cnt*BEATS + k, computed by a running address register with no multiplier. The address wraps modulo 2^ADDR_W.
- ReLU: when enabled, an element with MSB=1 is written as 0. Otherwise it is passed through unchanged.
- Output registers: ena at cycle t+1 reflects the issue decision at cycle t. Any cycle with wr_stall=1 issues nothing (ena=0 next cycle), and counters hold.
- Beats of a vector are consecutive absent stall. The next pop is allowed in the same cycle the last beat is issued, so back-to-back vectors have zero bubbles. Peak throughput is 1 beat/cycle.
- After vec_cnt reaches num and the final beat has been issued, go to DONE for one cycle (done=1), then return to IDLE.
- busy=1 in RUN and DONE.
- FIFO empty in RUN: idle without writing and wait.
- start while busy: ignored.
- Surplus FIFO vectors beyond num: they remain queued for the next run.

Decomposition:
- Package feature_writeback_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - helper localparam functions for BEATS/ADDR_W;
  - a relu function on NEW_FEATURE_WIDTH.
- Sub-module: the existing FIFO module, instantiated with DATA_WIDTH=NUM_FEATURE_OUT*NEW_FEATURE_WIDTH and FIFO_DEPTH=FIFO_DEPTH. No other sub-module.

Test Plan:
- Defaults, start base=0 num=2 relu=0. Push vectors with element i = i and 100+i. Expect 32 writes at addr 0..31, din = 0..15 then 100..115, no gaps, then done for 1 cycle 1 cycle after the last ena.
- NUM_LANES=4, base=8, num=1, element i = i. Expect 4 beats at addr 8..11, with beat 0 = {3,2,1,0} lanes packed low-first.
- relu_en=1, vector with element i = i-8 (two's complement). Expect elements 0..7 written as 0 and 8..15 unchanged. Rerun with relu_en=0: negatives pass through.
- wr_stall high for 3 cycles at beat 5 of a vector. Expect ena low for 3 cycles, then beat 5 written at addr 5 with no lost or duplicated beat.
- FIFO_DEPTH=4. Push 5 vectors in IDLE. Expect rdy=0 after the 4th, and the 5th is held. Then start num=5: all 80 beats are written in order, with rdy rising after the first pop.
- Assert rst at beat 7 of vector 0. Expect ena, busy and done=0 immediately. After release, start num=0: expect done pulse, no writes.
